// File: rtl/dcache_data_ram.sv
// D-cache data array: simple-dual-port RAM built from byte lanes, with a hardware zero-fill
// sweep, logic-implemented write-first bypass, and 1- or 2-cycle read latency with rvalid.

module dcache_data_ram_lane #(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [7:0]            wd,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   input  logic                  byp,
   output logic [7:0]            rd
);
   logic [7:0] mem [2**ADDR_WIDTH];
   logic [7:0] ram_q;
   logic [7:0] byp_d;
   logic       byp_q;

   always_ff @(posedge clk)
      if (we) mem[waddr] <= wd;

   // Bypass byte travels with the read so a same-cycle write wins without
   // relying on how the primitive resolves collisions.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ram_q <= '0;
         byp_q <= 1'b0;
         byp_d <= '0;
      end else if (re) begin
         ram_q <= mem[raddr];
         byp_q <= byp;
         byp_d <= wd;
      end

   assign rd = byp_q ? byp_d : ram_q;
endmodule

module dcache_data_ram #(
   parameter int    DATA_WIDTH     = 512,  // 32*Dcacheline_len*Dcache_way_num
   parameter int    ADDR_WIDTH     = 6,    // Dcache_index_bits
   parameter string WRITE_MODE     = "read_first",
   parameter int    READ_LATENCY   = 1,
   parameter bit    CLEAR_ON_RESET = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ren,
   input  logic [ADDR_WIDTH-1:0]   raddr,
   input  logic [DATA_WIDTH/8-1:0] wen,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic                    clear_req,
   output logic                    busy,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    rvalid
);
   localparam int NUM_LANES = DATA_WIDTH / 8;
   localparam int VEC_W     = 8;
   localparam bit WR_FIRST  = (WRITE_MODE == "write_first");
   localparam logic [ADDR_WIDTH:0] LAST_IDX = {1'b0, {ADDR_WIDTH{1'b1}}};
   localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic {IDLE, CLEAR} state_t;

   typedef struct packed {
      logic [NUM_LANES-1:0]             be;
      logic [ADDR_WIDTH-1:0]            addr;
      logic [NUM_LANES-1:0][VEC_W-1:0]  data;
   } wr_req_t;

   state_t                          state;
   logic [ADDR_WIDTH:0]             clr_cnt;
   wr_req_t                         wr;
   logic                            rd_acc;
   logic [NUM_LANES-1:0]            byp;
   logic [NUM_LANES-1:0][VEC_W-1:0] lane_rd;
   logic [DATA_WIDTH-1:0]           rd1;
   logic [READ_LATENCY:1]           vld_pipe;
   logic [READ_LATENCY:0]           vld_nxt;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state   <= CLEAR_ON_RESET ? CLEAR : IDLE;
         busy    <= CLEAR_ON_RESET;
         clr_cnt <= '0;
      end else begin
         case (state)
            IDLE:
               if (clear_req) begin
                  state   <= CLEAR;
                  busy    <= 1'b1;
                  clr_cnt <= '0;
               end
            CLEAR:
               if (clr_cnt == LAST_IDX) begin
                  state   <= IDLE;
                  busy    <= 1'b0;
                  clr_cnt <= '0;
               end else begin
                  clr_cnt <= clr_cnt + CNT_ONE;
               end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end

   // The sweep owns the write port while busy; user writes are dropped.
   always_comb begin
      wr.be   = wen;
      wr.addr = waddr;
      wr.data = wdata;
      if (busy) begin
         wr.be   = '1;
         wr.addr = clr_cnt[ADDR_WIDTH-1:0];
         wr.data = '0;
      end
   end

   assign rd_acc = ren & ~busy;
   assign byp    = wen & {NUM_LANES{WR_FIRST && rd_acc && (raddr == waddr)}};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      dcache_data_ram_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
         .clk   (clk),
         .reset (reset),
         .we    (wr.be[i]),
         .waddr (wr.addr),
         .wd    (wr.data[i]),
         .re    (rd_acc),
         .raddr (raddr),
         .byp   (byp[i]),
         .rd    (lane_rd[i])
      );
   end

   assign rd1 = lane_rd;

   assign vld_nxt = {vld_pipe, rd_acc};

   always_ff @(posedge clk or posedge reset)
      if (reset) vld_pipe <= '0;
      else       vld_pipe <= vld_nxt[READ_LATENCY-1:0];

   assign rvalid = vld_nxt[READ_LATENCY];

   if (READ_LATENCY == 2) begin : g_l2
      logic [DATA_WIDTH-1:0] rd2;
      always_ff @(posedge clk or posedge reset)
         if (reset)            rd2 <= '0;
         else if (vld_nxt[1])  rd2 <= rd1;
      assign rdata = rd2;
   end else begin : g_l1
      assign rdata = rd1;
   end
endmodule

// File: tb/tb_dcache_data_ram.sv
// Bench: read_first/latency-1 and write_first/latency-2 instances driven in lockstep,
// checked every cycle against an array-level model plus literal expectations.

module tb_dcache_data_ram;
   localparam int AW = 4, DW = 32, NB = 4, DEPTH = 16;

   logic          clk = 1'b0, rst = 1'b0, ren = 1'b0, clear_req = 1'b0;
   logic [AW-1:0] raddr = '0, waddr = '0;
   logic [NB-1:0] wen = '0;
   logic [DW-1:0] wdata = '0;
   logic          rf_busy, rf_rvalid, wf_busy, wf_rvalid;
   logic [DW-1:0] rf_rdata, wf_rdata;
   int            tests = 0, fails = 0;

   always #5 clk = ~clk;

   dcache_data_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE("read_first"),
                     .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) u_rf (
      .clk(clk), .reset(rst), .ren(ren), .raddr(raddr), .wen(wen), .waddr(waddr),
      .wdata(wdata), .clear_req(clear_req), .busy(rf_busy), .rdata(rf_rdata), .rvalid(rf_rvalid));

   dcache_data_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_MODE("write_first"),
                     .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)) u_wf (
      .clk(clk), .reset(rst), .ren(ren), .raddr(raddr), .wen(wen), .waddr(waddr),
      .wdata(wdata), .clear_req(clear_req), .busy(wf_busy), .rdata(wf_rdata), .rvalid(wf_rvalid));

   // Model: a plain word array, remaining-sweep count, and the expected output of each
   // configuration delayed by its read latency.
   logic [DW-1:0] mem [DEPTH];
   int            rem;
   logic          m_rf_v, m_w1_v, m_w2_v;
   logic [DW-1:0] m_rf_d, m_w1_d, m_w2_d;
   logic          acc;

   assign acc = ren && (rem == 0);

   function automatic logic [DW-1:0] wf_view();
      logic [DW-1:0] v;
      v = mem[raddr];
      for (int b = 0; b < NB; b++)
         if (raddr == waddr && wen[b]) v[8*b +: 8] = wdata[8*b +: 8];
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rem <= DEPTH;
         m_rf_v <= 1'b0; m_rf_d <= '0;
         m_w1_v <= 1'b0; m_w1_d <= '0;
         m_w2_v <= 1'b0; m_w2_d <= '0;
      end else begin
         m_rf_v <= acc;
         if (acc) m_rf_d <= mem[raddr];
         m_w1_v <= acc;
         if (acc) m_w1_d <= wf_view();
         m_w2_v <= m_w1_v;
         if (m_w1_v) m_w2_d <= m_w1_d;
         if (rem != 0) begin
            mem[DEPTH-rem] <= '0;
            rem <= rem - 1;
         end else begin
            for (int b = 0; b < NB; b++)
               if (wen[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            if (clear_req) rem <= DEPTH;
         end
      end
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("rf_busy",   rf_busy,   rem != 0);
      check("wf_busy",   wf_busy,   rem != 0);
      check("rf_rvalid", rf_rvalid, m_rf_v);
      check("rf_rdata",  rf_rdata,  m_rf_d);
      check("wf_rvalid", wf_rvalid, m_w2_v);
      check("wf_rdata",  wf_rdata,  m_w2_d);
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wen = '1; waddr = a; wdata = d;
      step();
      wen = '0;
   endtask

   task automatic wait_sweep(input int exp_len);
      int n;
      n = 0;
      while (rf_busy && n < 100) begin
         step();
         n++;
      end
      check("sweep_len", n, exp_len);
   endtask

   task automatic read_all_zero();
      for (int i = 0; i < DEPTH; i++) begin
         ren = 1'b1; raddr = i[AW-1:0];
         step();
         check("clr_rvalid", rf_rvalid, 1);
         check("clr_rdata",  rf_rdata,  0);
      end
      ren = 1'b0;
      step();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #1 rst = 1'b1;
      step();
      step();
      check("rst_busy",   rf_busy,   1);
      check("rst_rvalid", rf_rvalid, 0);
      check("rst_rdata",  wf_rdata,  0);
      rst = 1'b0;
      wait_sweep(16);
      read_all_zero();

      // Write then read; a write right after the read must not leak into it.
      do_write(3, 32'hA5A5A5A5);
      ren = 1'b1; raddr = 3;
      step();
      ren = 1'b0; wen = '1; waddr = 3; wdata = 32'h5A5A5A5A;
      check("rd3_rf_data",  rf_rdata,  32'hA5A5A5A5);
      check("rd3_rf_vld",   rf_rvalid, 1);
      check("rd3_wf_early", wf_rvalid, 0);
      step();
      wen = '0;
      check("rd3_wf_data", wf_rdata,  32'hA5A5A5A5);
      check("rd3_wf_vld",  wf_rvalid, 1);
      check("rd3_rf_done", rf_rvalid, 0);
      step();

      // Same-address collision with a low-byte write.
      do_write(5, 32'h11111111);
      ren = 1'b1; raddr = 5; wen = 4'b0001; waddr = 5; wdata = 32'hFFFFFFFF;
      step();
      ren = 1'b0; wen = '0;
      check("col_rf", rf_rdata, 32'h11111111);
      step();
      check("col_wf", wf_rdata, 32'h111111FF);
      ren = 1'b1; raddr = 5;
      step();
      ren = 1'b0;
      check("col_after", rf_rdata, 32'h111111FF);
      step();

      // Back-to-back reads.
      do_write(1, 32'd1);
      do_write(2, 32'd2);
      do_write(3, 32'd3);
      ren = 1'b1; raddr = 1;
      step();
      raddr = 2;
      check("b2b_rf1", rf_rdata, 1);
      check("b2b_rv1", rf_rvalid, 1);
      step();
      raddr = 3;
      check("b2b_rf2", rf_rdata, 2);
      check("b2b_wf1", wf_rdata, 1);
      step();
      ren = 1'b0;
      check("b2b_rf3", rf_rdata, 3);
      check("b2b_wf2", wf_rdata, 2);
      step();
      check("b2b_rf_hold", rf_rdata, 3);
      check("b2b_rf_nov",  rf_rvalid, 0);
      check("b2b_wf3",     wf_rdata, 3);
      check("b2b_wf_v3",   wf_rvalid, 1);
      step();
      check("b2b_wf_hold", wf_rdata, 3);
      check("b2b_wf_nov",  wf_rvalid, 0);

      // Reset in the middle of a sweep restarts it.
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      repeat (7) step();
      check("mid_busy", rf_busy, 1);
      rst = 1'b1;
      #1;
      check("mid_rf_data", rf_rdata, 0);
      check("mid_rf_vld",  rf_rvalid, 0);
      check("mid_wf_data", wf_rdata, 0);
      check("mid_wf_vld",  wf_rvalid, 0);
      step();
      step();
      rst = 1'b0;
      wait_sweep(16);
      read_all_zero();

      // Accesses during a requested sweep are ignored.
      do_write(7, 32'h77777777);
      clear_req = 1'b1;
      step();
      clear_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         ren = 1'b1; raddr = 7; wen = '1; waddr = i[AW-1:0]; wdata = 32'hDEADBEEF;
         step();
         check("busy_no_rv", rf_rvalid, 0);
      end
      ren = 1'b0; wen = '0;
      wait_sweep(11);
      read_all_zero();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dcache_data_ram.md
Name: dcache_data_ram

Overview:
Parametrised simple-dual-port data RAM for the D-cache data array. It is the next generation of the cache BRAM wrapper and adds:
- a hardware clear sweep after reset or on request;
- a selectable write mode, implemented in logic rather than left to the primitive;
- an optional second output register stage;
- a read-valid indication.

It sits between the D-cache controller and inferred block RAM, one instance per data array.

Parameters:
- DATA_WIDTH, 32*Dcacheline_len*Dcache_way_num: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, Dcache_index_bits: index width; depth = 2**ADDR_WIDTH.
- WRITE_MODE, "read_first": same-address read/write collision policy; legal values "read_first" and "write_first".
- READ_LATENCY, 1: cycles from accepted read to rdata/rvalid; legal values 1 and 2.
- CLEAR_ON_RESET, 1: when 1, the block zero-fills the whole array after reset release.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ren  in  1  read request.
- raddr  in  ADDR_WIDTH  read index.
- wen  in  DATA_WIDTH/8  per-byte write enables.
- waddr  in  ADDR_WIDTH  write index.
- wdata  in  DATA_WIDTH  write data.
- clear_req  in  1  one-cycle pulse; starts a zero-fill sweep.
- busy  out  1  sweep in progress; user reads and writes are ignored.
- rdata  out  DATA_WIDTH  read data.
- rvalid  out  1  rdata holds the result of a read accepted READ_LATENCY cycles earlier.

Behaviour:
- Reset (async, active-high)
  - state <= CLEAR if CLEAR_ON_RESET else IDLE; clear counter <= 0.
  - busy = (state==CLEAR), so busy resets to CLEAR_ON_RESET.
  - rdata <= 0, rvalid <= 0, all pipeline and bypass registers <= 0.
  - Array contents are not reset; only the sweep clears them.
- FSM IDLE
  - A read is accepted when ren=1.
  - Bytes with wen[i]=1 are written at waddr on the clock edge.
  - clear_req=1 -> CLEAR with counter=0. User accesses in that same cycle are still performed.
- FSM CLEAR
  - Each cycle: write all-zero at index counter with all bytes enabled; counter++.
  - At counter == 2**ADDR_WIDTH-1 the write completes and the FSM returns to IDLE. Sweep length is exactly 2**ADDR_WIDTH cycles.
  - ren, wen and clear_req are ignored while busy; no rvalid is generated.
  - Reads already in the output pipeline when the sweep starts still complete normally.
  - Reset asserted mid-sweep restarts per the reset rules above.
- Read pipeline
  - READ_LATENCY=1: array read registered once, so rdata/rvalid update on the edge after ren.
  - READ_LATENCY=2: one additional output register stage.
  - rvalid is a 1-cycle pulse per accepted read; back-to-back reads give back-to-back rvalid.
  - When no read completes, rdata holds its last value.
- Collision (ren=1, wen!=0, raddr==waddr, same cycle, state IDLE)
  - "read_first": returned data is the pre-write contents.
  - "write_first": returned data is merged per byte — wdata byte where wen[i]=1, else old byte.
  - Implementation: register hit flag, wen mask and wdata alongside the read stage; merge before the first output register. The result must not depend on primitive collision behaviour.
  - A write in the cycle after a read to the same address does not affect that read's result.
- Widths: the clear counter is ADDR_WIDTH+1 bits internally; comparisons use the full index with no truncation.

Test Plan:
1. CLEAR_ON_RESET=1, ADDR_WIDTH=4: pulse reset, then release -> busy=1 for exactly 16 cycles and then 0. Reads of every index then return 0 with rvalid one cycle after ren.
2. Write addr 3, wen all-1, data 0xA5A5...; next cycle ren addr 3 -> rdata 0xA5A5..., rvalid=1 for one cycle. With READ_LATENCY=2 the same appears one cycle later.
3. Collision at addr 5: old data 0x11..11; same-cycle write of 0xFF..FF with wen=0x0001.
   - read_first -> 0x11..11.
   - write_first -> 0x11..1FF (low byte new, rest old).
4. Pulse clear_req with ren/wen asserted for the next 5 cycles -> those accesses are ignored and no rvalid is produced. After busy drops, every index reads 0.
5. Assert reset at sweep cycle 7 of 16 -> rdata/rvalid go to 0 immediately. After release a full 16-cycle sweep runs again, then all indexes read 0.
6. Back-to-back reads of addr 1, 2, 3 (contents 1, 2, 3) -> rvalid high 3 consecutive cycles, rdata 1, 2, 3. Afterwards rdata holds 3 with rvalid=0.
